pattern_stream_tx: RTL and testbench

- Serial frame transmitter that drives the single-bit stream consumed by the team's 11010 pattern detector.
- Accepts a DATA_W-bit parallel word over a valid/ready handshake and emits one bit per clk:
  - the sync marker 1,1,0,1,0;
  - then the payload MSB-first, with bit-stuffing so that 11010 appears on the line only at the marker;
  - then a mandatory idle gap of zeros.
- Line idles at 0 between frames.

---
 rtl/pattern_stream_tx_if.sv | 11 +
 rtl/pattern_stream_tx.sv | 81 ++++++++
 tb/tb_pattern_stream_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pattern_stream_tx_if.sv
// pattern_stream_tx_if: payload handshake and serial line bundle of the frame transmitter
interface pattern_stream_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data_in;
  logic data_valid;
  logic data_ready;
  logic stream_out;
  logic frame_busy;
  logic frame_done;
  modport master (output data_in, data_valid, input data_ready, stream_out, frame_busy, frame_done);
  modport slave (input data_in, data_valid, output data_ready, stream_out, frame_busy, frame_done);
endinterface

// File: rtl/pattern_stream_tx.sv
// pattern_stream_tx: serial framer sending marker 11010, bit-stuffed MSB-first payload, then an idle-0 gap
module pattern_stream_tx #(
  parameter int DATA_W = 8,
  parameter int GAP_LEN = 2
) (
  input logic clk,
  input logic rst,
  pattern_stream_tx_if.slave bus
);
  localparam int MAX_DG = DATA_W > GAP_LEN ? DATA_W : GAP_LEN;
  localparam int CW = $clog2((MAX_DG > 5 ? MAX_DG : 5) + 1);
  localparam logic [4:0] MARKER = 5'b11010;
  localparam logic [3:0] STUFF_HIST = 4'b1101;
  typedef enum logic [2:0] {IDLE, MARK, DATA, STUFF, GAP} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [CW-1:0] cnt, cnt_n, rem;
  logic [3:0] hist;
  logic line, line_n, done, done_n;
  // state register with the line bit, line history, payload shifter and counter it steers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      hist <= '0;
      line <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      cnt <= cnt_n;
      hist <= {hist[2:0], line_n};
      line <= line_n;
      done <= done_n;
    end
  // next state and next line bit; cnt = marker bits sent in MARK, payload bits left in DATA/STUFF, zeros sent in GAP
  always_comb begin
    state_n = state;
    sh_n = sh;
    cnt_n = cnt;
    line_n = 1'b0;
    done_n = 1'b0;
    rem = state == MARK ? CW'(DATA_W) : cnt;
    if (state == IDLE) begin
      if (bus.data_valid) begin
        state_n = MARK;
        sh_n = bus.data_in;
        cnt_n = CW'(1);
        line_n = 1'b1;
      end
    end else if (state == MARK && cnt != CW'(5)) begin
      cnt_n = cnt + 1'b1;
      line_n = MARKER[3'(4 - int'(cnt))];
    end else if (state == GAP) begin
      state_n = cnt == CW'(GAP_LEN) ? IDLE : GAP;
      cnt_n = cnt + 1'b1;
    end else if (hist == STUFF_HIST) begin
      state_n = STUFF;
      cnt_n = rem;
      line_n = 1'b1;
      done_n = rem == '0;
    end else if (rem != '0) begin
      state_n = DATA;
      sh_n = sh << 1;
      cnt_n = rem - 1'b1;
      line_n = sh[DATA_W-1];
      done_n = rem == CW'(1) && {hist[2:0], sh[DATA_W-1]} != STUFF_HIST;
    end else begin
      state_n = GAP;
      cnt_n = CW'(1);
    end
  end
  // handshake and framing flags decoded from the state register
  always_comb begin
    bus.data_ready = state == IDLE;
    bus.frame_busy = state == MARK || state == DATA || state == STUFF;
  end
  assign bus.stream_out = line;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_pattern_stream_tx.sv
// tb_pattern_stream_tx: 8- and 5-bit transmitters checked cycle by cycle against a frame-building model
module tb_pattern_stream_tx;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid [2];
  logic [7:0] din [2];
  logic line [2], busy [2], done [2], ready [2];
  int cmp = 0, bad = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // whole frame as the line must carry it: marker, payload with a 1 inserted after every 1101, optional trailing 1
  function automatic void build(input logic [7:0] w, input int n, output logic [0:31] f, output int len);
    f = '0;
    f[0:4] = 5'b11010;
    len = 5;
    for (int i = n - 1; i >= -1; i--) begin
      if ({f[len-4], f[len-3], f[len-2], f[len-1]} == 4'b1101) begin
        f[len] = 1'b1;
        len++;
      end
      if (i >= 0) begin
        f[len] = w[i];
        len++;
      end
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = g == 0 ? 8 : 5;
    pattern_stream_tx_if #(.DATA_W(W)) bus ();
    pattern_stream_tx #(.DATA_W(W), .GAP_LEN(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.data_valid = valid[g];
    assign bus.data_in = din[g][W-1:0];
    assign line[g] = bus.stream_out;
    assign busy[g] = bus.frame_busy;
    assign done[g] = bus.frame_done;
    assign ready[g] = bus.data_ready;
    logic [3:0] q [$];
    logic [7:0] words [$];
    logic [4:0] h5 = '0;
    logic [3:0] e, p4;
    logic [7:0] got = '0;
    logic [0:31] f;
    int len, n = 0, dets = 0, lds = 0;
    bit col = 1'b0;
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        words.delete();
        col = 1'b0;
      end else if (q.size() != 0) begin
        void'(q.pop_front());
      end else if (valid[g]) begin
        build(din[g], W, f, len);
        for (int k = 0; k < len; k++) q.push_back({f[k], 1'b1, k == len - 1, k == 4});
        for (int k = 0; k < GAP; k++) q.push_back(4'b0);
        words.push_back(din[g] & 8'((1 << W) - 1));
        lds++;
      end
      #1;
      e = q.size() != 0 ? q[0] : 4'b0;
      p4 = h5[3:0];
      h5 = {h5[3:0], line[g]};
      if (h5 == 5'b11010) dets++;
      chk($sformatf("outs%0d", g), {line[g], busy[g], done[g], h5 == 5'b11010, ready[g]}, {e, q.size() == 0});
      if (col && p4 != 4'b1101) begin
        got = {got[6:0], line[g]};
        n++;
        if (n == W) begin
          col = 1'b0;
          chk($sformatf("payload%0d", g), {24'b0, got}, words.size() != 0 ? {24'b0, words.pop_front()} : 32'hffff_ffff);
        end
      end
      if (h5 == 5'b11010) begin
        col = 1'b1;
        n = 0;
        got = '0;
      end
    end
  end

  task automatic send(input int g, input logic [7:0] w, input bit hold);
    int t;
    t = 0;
    @(negedge clk);
    valid[g] = 1'b1;
    din[g] = w;
    while (!ready[g] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      cmp++;
      bad++;
      $display("FAIL handshake%0d: ready stayed 0 for %0d cycles", g, t);
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      valid[g] = 1'b0;
      din[g] = ~w;
    end
  endtask

  task automatic rand_run(input int g);
    bit h;
    for (int i = 0; i < 1000; i++) begin
      h = 1'($urandom_range(0, 1));
      send(g, 8'($urandom), h);
      if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    valid[g] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [0:31] pf;
    int plen, t, d0;
    for (int g = 0; g < 2; g++) begin
      valid[g] = 1'b0;
      din[g] = '0;
    end
    build(8'h00, 8, pf, plen);
    chk("pin_00_len", plen, 13);
    chk("pin_00_bits", pf[0:12], 13'b1101000000000);
    build(8'hD0, 8, pf, plen);
    chk("pin_D0_len", plen, 14);
    chk("pin_D0_bits", pf[0:13], 14'b11010110110000);
    build(8'h0D, 8, pf, plen);
    chk("pin_0D_len", plen, 14);
    chk("pin_0D_bits", pf[0:13], 14'b11010000011011);
    repeat (2) @(negedge clk);
    chk("reset_outs", {line[0], busy[0], done[0], ready[0]}, 4'b0001);
    rst = 1'b0;
    send(0, 8'h00, 1'b0);
    t = 1;
    while (!done[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_cycle_00", t, 13);
    t = 0;
    while (!ready[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ready_after_done_00", t, 3);
    send(0, 8'hD0, 1'b0);
    t = 0;
    while (busy[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("busy_len_D0", t, 14);
    send(0, 8'h0D, 1'b0);
    t = 1;
    while (!done[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("done_cycle_0D", t, 14);
    chk("done_bit_0D", line[0], 1);
    d0 = u[0].dets;
    send(0, 8'hFF, 1'b1);
    send(0, 8'hDA, 1'b1);
    send(0, 8'h6B, 1'b0);
    repeat (24) @(negedge clk);
    chk("b2b_dets", u[0].dets - d0, 3);
    send(0, 8'hAA, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_outs", {line[0], busy[0], done[0], ready[0]}, 4'b0001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(0, 8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (30) @(negedge clk);
    chk("frames0", u[0].dets, u[0].lds);
    chk("frames1", u[1].dets, u[1].lds);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
